// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the execution trace buffer.
//   - capture state encoding (IDLE/ARMED/CAPTURE/DONE)
//   - field widths of one captured sample (PC 32, INST 32, ALU 16)
//   - entry packing order {ts, pc, inst, alu}; the timestamp field only
//     exists when TRACE_TIMESTAMP_EN is defined and sits above BASE_W.
package trace_pkg;

  localparam int PC_W     = 32;
  localparam int INST_W   = 32;
  localparam int ALU_W    = 16;
  localparam int BASE_W   = PC_W + INST_W + ALU_W;

  // Bit offsets of each field inside a packed entry.
  localparam int ALU_LSB  = 0;
  localparam int INST_LSB = ALU_LSB + ALU_W;
  localparam int PC_LSB   = INST_LSB + INST_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  // Packs the timestamp-free part of an entry as {pc, inst, alu}.
  function automatic logic [BASE_W-1:0] pack_base(
    input logic [PC_W-1:0]   pc,
    input logic [INST_W-1:0] inst,
    input logic [ALU_W-1:0]  alu
  );
    return {pc, inst, alu};
  endfunction

endpackage

// File: rtl/trace_capture_if.sv
// trace_capture_if: host-side read port of the trace buffer.
//   rd_valid  head entry available          (buffer -> host)
//   rd_ready  host accepts head entry       (host -> buffer)
//   rd_pc / rd_inst / rd_alu  head entry fields
//   rd_ts     head entry timestamp, present only with TRACE_TIMESTAMP_EN
// Modports: master = trace buffer side, slave = debug host side.
interface trace_capture_if
`ifdef TRACE_TIMESTAMP_EN
  #(parameter int TS_W = 16)
`endif
  ();
  import trace_pkg::*;

  logic              rd_valid;
  logic              rd_ready;
  logic [PC_W-1:0]   rd_pc;
  logic [INST_W-1:0] rd_inst;
  logic [ALU_W-1:0]  rd_alu;
`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]   rd_ts;
`endif

  modport master (
    output rd_valid,
    output rd_pc,
    output rd_inst,
    output rd_alu,
`ifdef TRACE_TIMESTAMP_EN
    output rd_ts,
`endif
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_pc,
    input  rd_inst,
    input  rd_alu,
`ifdef TRACE_TIMESTAMP_EN
    input  rd_ts,
`endif
    output rd_ready
  );

endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: DEPTH x W circular storage for captured trace entries.
// Ports:
//   clk, reset    clock, asynchronous active-high reset (clears storage too,
//                 so the head fields read zero straight out of reset)
//   push, wr_data write one entry at the write pointer
//   pop           drop the head entry (ignored when empty)
//   flush         synchronous clear of pointers and count; beats push/pop
//   rd_data       storage at the read pointer, combinational
//   count         entries currently held
// The producer guarantees no push while full, so no overflow guard here.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 80,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     wr_data,
  output logic [W-1:0]     rd_data,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             pop_s;

  // A pop only counts when there is something to remove
  always_comb begin
    pop_s = 1'b0;
    if (pop && (count_r != '0)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Storage, pointers and occupancy; pointers wrap modulo DEPTH naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r        <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;

endmodule

// File: rtl/trace_capture.sv
// trace_capture: on-chip execution trace buffer.
// Waits (when armed) for a retired sample whose PC equals trig_pc, then
// records that sample and the following ones until DEPTH entries have been
// written. A debug host drains entries over the rd valid/ready port.
// Optional feature macro: TRACE_TIMESTAMP_EN adds a free-running TS_W-bit
// cycle counter whose value at the write edge is stored with each entry and
// presented on rd.rd_ts.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   arm                   arm request (IDLE/DONE only; DONE also flushes)
//   trig_pc               PC value that starts capture
//   sample_valid          debug_* hold a retired instruction this cycle
//   debug_pc/inst/alu_out processor debug outputs
//   rd                    read port (trace_capture_if.master)
//   state                 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   count                 entries currently buffered
module trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
`ifdef TRACE_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm,
  input  logic [PC_W-1:0]        trig_pc,
  input  logic                   sample_valid,
  input  logic [PC_W-1:0]        debug_pc,
  input  logic [INST_W-1:0]      debug_inst,
  input  logic [ALU_W-1:0]       debug_alu_out,
  trace_capture_if.master        rd,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = BASE_W + TS_W;
`else
  localparam int ENTRY_W = BASE_W;
`endif

  cap_state_e         state_r;
  cap_state_e         state_nxt_s;
  logic [CNT_W-1:0]   wr_cnt_r;
  logic [CNT_W-1:0]   fifo_cnt_s;
  logic               trig_hit_s;
  logic               push_s;
  logic               pop_s;
  logic               flush_s;
  logic               arm_ok_s;
  logic [ENTRY_W-1:0] entry_s;
  logic [ENTRY_W-1:0] head_s;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]    ts_r;

  // Free-running cycle counter, wraps at 2^TS_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_r <= '0;
    end else begin
      ts_r <= ts_r + TS_W'(1);
    end
  end

  assign entry_s = {ts_r, pack_base(debug_pc, debug_inst, debug_alu_out)};
`else
  assign entry_s = pack_base(debug_pc, debug_inst, debug_alu_out);
`endif

  // Capture FSM next-state and per-cycle push/flush decisions
  always_comb begin
    state_nxt_s = state_r;
    push_s      = 1'b0;
    flush_s     = 1'b0;
    arm_ok_s    = 1'b0;
    trig_hit_s  = sample_valid && (debug_pc == trig_pc);
    case (state_r)
      ST_IDLE: begin
        if (arm) begin
          arm_ok_s    = 1'b1;
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        // The matching sample itself is the first entry.
        if (trig_hit_s) begin
          push_s      = 1'b1;
          state_nxt_s = ST_CAPTURE;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        if (sample_valid) begin
          push_s = 1'b1;
          // wr_cnt_r counts writes before this one; this is the DEPTH-th.
          if (wr_cnt_r == CNT_W'(DEPTH - 1)) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CAPTURE;
          end
        end else begin
          state_nxt_s = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        if (arm) begin
          arm_ok_s    = 1'b1;
          flush_s     = 1'b1;
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Capture state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Entries written since trigger; saturates at DEPTH, cleared by an accepted arm
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_r <= '0;
    end else if (arm_ok_s) begin
      wr_cnt_r <= '0;
    end else if (push_s && (wr_cnt_r != CNT_W'(DEPTH))) begin
      wr_cnt_r <= wr_cnt_r + CNT_W'(1);
    end else begin
      wr_cnt_r <= wr_cnt_r;
    end
  end

  // The FIFO gives flush priority, so a pop coinciding with an arm in DONE is dropped.
  assign pop_s = rd.rd_valid && rd.rd_ready;

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (flush_s),
    .wr_data (entry_s),
    .rd_data (head_s),
    .count   (fifo_cnt_s)
  );

  assign rd.rd_valid = (fifo_cnt_s != '0);
  assign rd.rd_pc    = head_s[PC_LSB +: PC_W];
  assign rd.rd_inst  = head_s[INST_LSB +: INST_W];
  assign rd.rd_alu   = head_s[ALU_LSB +: ALU_W];
`ifdef TRACE_TIMESTAMP_EN
  assign rd.rd_ts    = head_s[BASE_W +: TS_W];
`endif

  assign state = state_r;
  assign count = fifo_cnt_s;

endmodule
